// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD conversion slice.
// Imported by the dabble core and the requester scheduler.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NIBBLE_CORR_THRESH = 5;

  // Decimal digits needed to hold 2^w - 1.
  function automatic int digits_for_width(input int w);
    longint unsigned v;
    int d;
    v = (64'd1 << w) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        d++;
        v = v / 10;
      end
    end
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Sequential shift-and-add-3 engine: one iteration per cycle.
// Holds the finished BCD value until the next start.
module bcd_dabble_core
  import bcd_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       operand_i,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  localparam int IT_W = $clog2(DATA_W) + 1;
  localparam int BW   = 4 * BCD_DIGITS;

  logic [DATA_W-1:0] bin_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     corr;
  logic [IT_W-1:0]   iter_q;
  logic              run_q;

  always_comb begin
    corr = '0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'(NIBBLE_CORR_THRESH))
        corr[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      else
        corr[4*d +: 4] = bcd_q[4*d +: 4];
    end
  end

  // High on the edge that performs the final iteration.
  assign done_o = run_q && (iter_q == IT_W'(DATA_W - 1));
  assign bcd_o  = bcd_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
    end else if (start_i) begin
      bin_q  <= operand_i;
      bcd_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      bcd_q  <= {corr[BW-2:0], bin_q[DATA_W-1]};
      bin_q  <= {bin_q[DATA_W-2:0], 1'b0};
      iter_q <= iter_q + 1'b1;
      if (done_o)
        run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin front end sharing one dabble core among requesters,
// with a backpressured response port.
module bcd_conv_scheduler
  import bcd_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int BCD_DIGITS = 3,
  parameter int ID_W       = 2
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [4*BCD_DIGITS-1:0]   rsp_bcd,
  output logic                      busy,
  output logic [15:0]               conv_count
);

  localparam int CW = ID_W + 1;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q;
  logic [15:0]       cnt_q;
  logic [ID_W-1:0]   grant;
  logic              grant_vld;
  logic [CW-1:0]     cand;
  logic [DATA_W-1:0] operand;
  logic              accept;
  logic              core_done;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ))
        cand = cand - CW'(NUM_REQ);
      if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    operand = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant == ID_W'(i))
        operand = req_data[i*DATA_W +: DATA_W];
  end

  assign accept = (state_q == IDLE) && grant_vld;

  // Gated by reset so the grant is silent while reset is held.
  assign req_ready = (accept && sys_rst_n)
                   ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant)
                   : '0;

  assign rr_ptr_d = (grant == ID_W'(NUM_REQ - 1))
                  ? '0 : grant + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = CONV;
      CONV:    if (core_done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      rsp_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_ptr_q <= rr_ptr_d;
        rsp_id_q <= grant;
      end
      if (state_q == RESP && rsp_ready && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  bcd_dabble_core #(
    .DATA_W     (DATA_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_core (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start_i   (accept),
    .operand_i (operand),
    .done_o    (core_done),
    .bcd_o     (rsp_bcd)
  );

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != IDLE);
  assign conv_count = cnt_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_bcd_conv_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [11:0]   rsp_bcd;
  logic          busy;
  logic [15:0]   conv_count;

  bcd_conv_scheduler dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_bcd    (rsp_bcd),
    .busy       (busy),
    .conv_count (conv_count)
  );

  always #5 sys_clk = ~sys_clk;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int acc_cyc = 0;
  int rise_cyc = 0;
  logic prev_rv = 1'b0;
  int glog[$];
  int ilog[$];
  logic [11:0] blog[$];
  logic [N-1:0] hold;

  // Model: 0 idle, 1 converting (m_wait cycles left), 2 result offered.
  int m_ph, m_wait, m_ptr, m_id, m_done, m_val;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_wait = 0; m_ptr = 0;
    m_id = 0; m_done = 0; m_val = 0;
  endtask

  task automatic model_step();
    int w;
    if (!sys_rst_n) begin
      model_reset();
    end else if (m_ph == 0) begin
      w = winner();
      if (w >= 0) begin
        m_id   = w;
        m_val  = int'(req_data[w*DW +: DW]);
        m_ptr  = (w + 1) % N;
        m_wait = DW;
        m_ph   = 1;
      end
    end else if (m_ph == 1) begin
      m_wait--;
      if (m_wait == 0) m_ph = 2;
    end else if (rsp_ready) begin
      if (m_done < 65535) m_done++;
      m_ph = 0;
    end
  endtask

  task automatic compare();
    int w;
    logic [N-1:0] er;
    if (!sys_rst_n) begin
      chk("rst req_ready", 32'(req_ready), 0);
      chk("rst rsp_valid", 32'(rsp_valid), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst rsp_id", 32'(rsp_id), 0);
      chk("rst rsp_bcd", 32'(rsp_bcd), 0);
      chk("rst conv_count", 32'(conv_count), 0);
    end else begin
      w  = winner();
      er = (m_ph == 0 && w >= 0) ? N'(1 << w) : '0;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 2));
      chk("conv_count", 32'(conv_count), 32'(m_done));
      if (m_ph == 2) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_bcd", 32'(rsp_bcd), 32'(to_bcd(m_val)));
      end
    end
  endtask

  task automatic tick();
    logic acc;
    int ai;
    @(negedge sys_clk);
    cyc++;
    compare();
    acc = |(req_valid & req_ready);
    ai  = 0;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) ai = i;
    if (acc) begin
      glog.push_back(ai);
      acc_cyc = cyc;
    end
    if (rsp_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      hs_cnt++;
      ilog.push_back(int'(rsp_id));
      blog.push_back(rsp_bcd);
    end
    model_step();
    @(posedge sys_clk);
    #1;
    if (acc && !hold[ai]) req_valid[ai] = 1'b0;
  endtask

  task automatic wait_hs(input int n, input string nm);
    int tgt;
    int b;
    tgt = hs_cnt + n;
    b = 0;
    while (hs_cnt < tgt && b < 200) begin
      tick();
      b++;
    end
    chk({nm, " handshake"}, 32'(hs_cnt >= tgt), 1);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
  endtask

  function automatic int last_i();
    return (ilog.size() > 0) ? ilog[ilog.size()-1] : -1;
  endfunction

  function automatic int last_b();
    return (blog.size() > 0) ? int'(blog[blog.size()-1]) : -1;
  endfunction

  function automatic int last_g();
    return (glog.size() > 0) ? glog[glog.size()-1] : -1;
  endfunction

  int evals[5] = '{0, 9, 10, 99, 100};
  logic [11:0] eexp[5] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100};
  int base;
  int b;
  logic [11:0] snap_b;
  logic [1:0] snap_i;

  initial begin
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    hold      = '0;
    sys_rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();

    // Single request from requester 1.
    req_data[15:8] = 8'd255;
    req_valid = 4'b0010;
    tick();
    chk("single grant", 32'(last_g()), 1);
    wait_hs(1, "single");
    chk("single latency", 32'(rise_cyc - acc_cyc - 1), 8);
    chk("single id", 32'(last_i()), 1);
    chk("single bcd", 32'(last_b()), 32'h255);

    // Edge values, rotated across requesters.
    for (int i = 0; i < 5; i++) begin
      req_data[(i % N)*DW +: DW] = 8'(evals[i]);
      req_valid[i % N] = 1'b1;
      wait_hs(1, "edge");
      chk("edge bcd", 32'(last_b()), 32'(eexp[i]));
    end

    // Full contention.
    do_reset();
    req_data = {8'd200, 8'd128, 8'd99, 8'd10};
    req_valid = 4'b1111;
    base = ilog.size();
    wait_hs(4, "contend");
    for (int i = 0; i < 4; i++) begin
      chk("contend id", 32'((ilog.size() > base + i)
          ? ilog[base + i] : -1), 32'(i));
    end
    chk("contend bcd0", 32'(blog[base]), 32'h010);
    chk("contend bcd1", 32'(blog[base + 1]), 32'h099);
    chk("contend bcd2", 32'(blog[base + 2]), 32'h128);
    chk("contend bcd3", 32'(blog[base + 3]), 32'h200);
    chk("contend count", 32'(conv_count), 4);
    req_valid = 4'b1001;
    tick();
    chk("wrap grant", 32'(last_g()), 0);
    req_valid = '0;
    wait_hs(1, "wrap");

    // Fairness: requester 2 holds, requester 0 asks once.
    do_reset();
    hold = 4'b0100;
    req_data[23:16] = 8'd77;
    req_data[7:0]   = 8'd5;
    req_valid = 4'b0100;
    base = glog.size();
    tick();
    req_valid[0] = 1'b1;
    wait_hs(3, "fair");
    chk("fair g0", 32'((glog.size() > base) ? glog[base] : -1), 2);
    chk("fair g1", 32'((glog.size() > base + 1) ? glog[base + 1] : -1), 0);
    chk("fair g2", 32'((glog.size() > base + 2) ? glog[base + 2] : -1), 2);
    req_valid = '0;
    hold = '0;

    // Backpressure.
    rsp_ready = 1'b0;
    req_data[31:24] = 8'd123;
    req_valid = 4'b1000;
    b = 0;
    while (!rsp_valid && b < 50) begin
      tick();
      b++;
    end
    chk("bp rsp_valid", 32'(rsp_valid), 1);
    snap_b = rsp_bcd;
    snap_i = rsp_id;
    chk("bp bcd", 32'(snap_b), 32'h123);
    chk("bp id", 32'(snap_i), 3);
    hold = 4'b0111;
    req_valid = 4'b0111;
    repeat (20) begin
      tick();
      chk("bp hold valid", 32'(rsp_valid), 1);
      chk("bp hold bcd", 32'(rsp_bcd), 32'(snap_b));
      chk("bp hold id", 32'(rsp_id), 32'(snap_i));
      chk("bp req_ready", 32'(req_ready), 0);
    end
    req_valid = '0;
    hold = '0;
    rsp_ready = 1'b1;
    base = hs_cnt;
    repeat (4) tick();
    chk("bp one handshake", 32'(hs_cnt - base), 1);

    // Reset in the middle of a conversion.
    req_data[15:8] = 8'd55;
    req_valid = 4'b0010;
    tick();
    repeat (4) tick();
    req_valid = 4'b1010;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid rst req_ready", 32'(req_ready), 0);
    chk("mid rst rsp_valid", 32'(rsp_valid), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst bcd", 32'(rsp_bcd), 0);
    chk("mid rst id", 32'(rsp_id), 0);
    chk("mid rst count", 32'(conv_count), 0);
    repeat (3) tick();
    req_data[15:8]  = 8'd42;
    req_data[31:24] = 8'd42;
    sys_rst_n = 1'b1;
    wait_hs(1, "post rst");
    chk("post rst id", 32'(last_i()), 1);
    chk("post rst bcd", 32'(last_b()), 32'h042);
    req_valid = '0;

    // Random traffic.
    hold = '1;
    for (int i = 0; i < 3000; i++) begin
      req_valid = N'($urandom);
      req_data  = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      sys_rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    sys_rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bcd_conv_scheduler.md
# bcd_conv_scheduler

Shares one sequential binary-to-BCD conversion engine among `NUM_REQ` requesters, such as display channels or UART formatters, using round-robin arbitration. Each request is accepted with a valid/ready handshake. The block latches the binary operand, runs the shift-and-add-3 engine for `DATA_W` iterations, and returns the packed BCD result with the winning requester's index on a single response port that supports backpressure. It sits between the producers of binary values and the display/formatting logic downstream.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `DATA_W`, default 8: binary operand width.
- `BCD_DIGITS`, default 3: result digits; must satisfy 10^BCD_DIGITS > 2^DATA_W − 1.
- `ID_W`, default 2: requester index width; equals clog2(`NUM_REQ`).

Ports:
- `sys_clk`  in  1: clock; all logic on the rising edge.
- `sys_rst_n`  in  1: asynchronous reset, active-low.
- `req_valid`  in  `NUM_REQ`: per-requester request strobe.
- `req_data`  in  `NUM_REQ`*`DATA_W`: operands; requester i occupies bits [i*`DATA_W` +: `DATA_W`].
- `req_ready`  out  `NUM_REQ`: one-hot grant; at most one bit high.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: downstream accepts the result.
- `rsp_id`  out  `ID_W`: index of the requester that owns the result.
- `rsp_bcd`  out  4*`BCD_DIGITS`: packed BCD result; digit 0 (units) is in bits [3:0].
- `busy`  out  1: high in every state except IDLE.
- `conv_count`  out  16: completed conversions, saturating at 16'hFFFF.

## Operation
- FSM states: IDLE, CONV, RESP.
- IDLE:
  - The round-robin arbiter selects the first asserted `req_valid` at or after `rr_ptr`, searching upward with wrap.
  - `req_ready` for the winner is driven combinationally. Acceptance occurs on the edge where `req_valid[i]` and `req_ready[i]` are both high.
  - On acceptance: latch the operand and index, clear the BCD field, set `iter` to 0, set `rr_ptr` to (winner+1) mod `NUM_REQ`, and go to CONV.
  - With no `req_valid` asserted, remain in IDLE and hold `rr_ptr`.
- CONV: each cycle performs one double-dabble iteration.
  - Every BCD nibble ≥5 has 3 added.
  - The combined {bcd, operand} register then shifts left by 1.
  - `iter` increments each cycle. When `iter` == `DATA_W`−1, go to RESP.
- RESP:
  - `rsp_valid` = 1, and `rsp_bcd` / `rsp_id` are held stable.
  - On `rsp_valid` && `rsp_ready`: increment `conv_count` (saturating) and go to IDLE.
  - With `rsp_ready` low, hold indefinitely.
- `req_ready` is 0 in CONV and RESP. Operands are captured at acceptance, so requesters may change `req_data` afterwards.
- Arithmetic: the nibble-correct uses a 4-bit add; a nibble ≥5 cannot overflow. `iter` has width clog2(`DATA_W`)+1.
- Reset, at any time including mid-CONV or RESP:
  - State returns to IDLE and `rr_ptr` to 0.
  - All outputs go to 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_bcd`, `busy`, `conv_count`.
  - The in-flight conversion is discarded with no response.

## Timing
- Acceptance edge T0.
- CONV occupies the cycles after edges T0 .. T0+`DATA_W`−1.
- `rsp_valid` rises after edge T0+`DATA_W`, which is 8 cycles for the defaults.
- The earliest next acceptance is the cycle after the response handshake edge.
- Peak throughput with `rsp_ready` tied high is one result per `DATA_W`+2 cycles.
- `req_ready` depends combinationally on `req_valid` and the state only; it does not depend on `rsp_ready`.
- A requester that drops `req_valid` before being granted is never served. Requests are level-sensitive and are not queued.

## Structure
- Shared package `bcd_pkg`:
  - state enum {IDLE, CONV, RESP}.
  - function `digits_for_width(w)`.
  - constant `NIBBLE_CORR_THRESH` = 5.
- Sub-module `bcd_dabble_core`:
  - Interface: start, operand, done, bcd; parameterised by `DATA_W` and `BCD_DIGITS`.
  - It owns the shift register and `iter`.
  - The scheduler owns arbitration, the FSM, and the response register.

## Test plan
- **Single request:** requester 1 drives 8'd255 with other lines idle. Required: `req_ready` = 4'b0010 for one cycle, `rsp_valid` 8 cycles later, `rsp_bcd` = 12'h255, `rsp_id` = 1.
- **Edge values:** 8'd0 → 12'h000; 8'd9 → 12'h009; 8'd10 → 12'h010; 8'd99 → 12'h099; 8'd100 → 12'h100.
- **Full contention:** all four requesters hold `req_valid` with operands 10, 99, 128, 200. Required: responses arrive in order id 0, 1, 2, 3 with BCD 12'h010, 12'h099, 12'h128, 12'h200. The next grant wraps to id 0, and `conv_count` = 4.
- **Fairness:** requester 2 holds `req_valid` continuously while requester 0 asserts once. Required: after a grant to 2, the next grant goes to 0; requester 2 is never granted twice in a row while 0 is pending.
- **Backpressure:** hold `rsp_ready` = 0 for 20 cycles during RESP. Required: `rsp_valid`, `rsp_bcd` and `rsp_id` stay stable, and `req_ready` stays 0 throughout. When `rsp_ready` rises, there is exactly one handshake.
- **Reset mid-conversion:** assert `sys_rst_n` = 0 at iteration 4. Required: outputs go to 0 immediately and no `rsp_valid` appears. After release, a fresh request for 8'd42 returns 12'h042 with `rsp_id` taken from the arbitration restart at `rr_ptr` = 0.
